// File: rtl/bus_arb_pkg.sv
// ============================================================================
// Module : bus_arb_pkg
// Brief  : Shared types, default sizes and index-width helper for bus_arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bus_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int BUS_ARB_WIDTH = 16;
  localparam int BUS_ARB_N_SRC = 13;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_arb_pick.sv
// ============================================================================
// Module : bus_arb_pick
// Brief  : Combinational rotated priority picker; searches upward from start_i.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_arb_pick
  import bus_arb_pkg::*;
#(
  parameter int N_SRC = BUS_ARB_N_SRC,
  parameter int IDX_W = idx_w(BUS_ARB_N_SRC)
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic [N_SRC-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  logic found;
  int   idx;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 0; off < N_SRC; off++) begin
      idx = int'(start_i) + off;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!found && req_i[idx]) begin
        found         = 1'b1;
        onehot_o[idx] = 1'b1;
        idx_o         = IDX_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module : bus_arbiter
// Brief  : Registered N-source bus arbiter, fixed or round-robin, with lock.
//          Conflict flag/counter built only when BUS_ARB_CONFLICT_CNT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int        WIDTH = BUS_ARB_WIDTH,
  parameter int        N_SRC = BUS_ARB_N_SRC,
  parameter arb_mode_e MODE  = ARB_FIXED
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  input  logic [N_SRC-1:0]       read_en,
  input  logic                   lock,
  output logic [WIDTH-1:0]       bus,
  output logic                   bus_valid,
  output logic [N_SRC-1:0]       grant,
  output logic                   conflict,
  output logic [15:0]            conflict_cnt
);

  localparam int               IDX_W    = idx_w(N_SRC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

  logic [WIDTH-1:0] src_arr [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_unpack
    assign src_arr[i] = src_data[i*WIDTH +: WIDTH];
  end

  logic [WIDTH-1:0] bus_q, bus_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic [IDX_W-1:0] pick_start;
  logic [N_SRC-1:0] pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             lock_hold;

  assign pick_start = (MODE == ARB_RR) ? ptr_q : '0;

  bus_arb_pick #(
    .N_SRC (N_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i    (read_en),
    .start_i  (pick_start),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  // Lock only binds while there is a current owner still requesting.
  assign lock_hold = lock && (grant_q != '0) && ((read_en & grant_q) != '0);

  always_comb begin
    bus_d   = bus_q;
    grant_d = '0;
    valid_d = 1'b0;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (read_en != '0) begin
      valid_d = 1'b1;
      if (lock_hold) begin
        grant_d = grant_q;
      end else begin
        grant_d = pick_oh;
        owner_d = pick_idx;
        if (MODE == ARB_RR) begin
          ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDX_W'(1);
        end
      end
      bus_d = src_arr[owner_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      bus_q   <= bus_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  assign bus       = bus_q;
  assign bus_valid = valid_q;
  assign grant     = grant_q;

`ifdef BUS_ARB_CONFLICT_CNT_EN
  localparam logic [N_SRC-1:0] ONE = N_SRC'(1);

  logic        multi_req;
  logic        conflict_q;
  logic [15:0] cnt_q, cnt_d;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_req = (read_en & (read_en - ONE)) != '0;

  always_comb begin
    cnt_d = cnt_q;
    if (multi_req && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      conflict_q <= multi_req;
      cnt_q      <= cnt_d;
    end
  end

  assign conflict     = conflict_q;
  assign conflict_cnt = cnt_q;
`else
  assign conflict     = 1'b0;
  assign conflict_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module : tb_bus_arbiter
// Brief  : Self-checking bench for bus_arbiter, fixed and round-robin instances.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int W = 16;
  localparam int N = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N*W-1:0] src;
  logic [N-1:0] re;
  logic         lk;

  logic [W-1:0] bus_f, bus_r;
  logic         val_f, val_r;
  logic [N-1:0] gnt_f, gnt_r;
  logic         cf_f, cf_r;
  logic [15:0]  cnt_f, cnt_r;

  bus_arbiter #(.WIDTH(W), .N_SRC(N), .MODE(ARB_FIXED)) dut_fix (
    .clk(clk), .rst(rst), .src_data(src), .read_en(re), .lock(lk),
    .bus(bus_f), .bus_valid(val_f), .grant(gnt_f),
    .conflict(cf_f), .conflict_cnt(cnt_f)
  );

  bus_arbiter #(.WIDTH(W), .N_SRC(N), .MODE(ARB_RR)) dut_rr (
    .clk(clk), .rst(rst), .src_data(src), .read_en(re), .lock(lk),
    .bus(bus_r), .bus_valid(val_r), .grant(gnt_r),
    .conflict(cf_r), .conflict_cnt(cnt_r)
  );

  typedef struct {
    logic [N-1:0] g_f;
    logic [W-1:0] b_f;
    logic         v_f;
    logic [N-1:0] g_r;
    logic [W-1:0] b_r;
    logic         v_r;
    logic         cf;
    logic [15:0]  cnt;
    bit           chk;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [N-1:0] mg_f = '0, mg_r = '0;
  logic [W-1:0] mb_f = '0, mb_r = '0;
  logic         mv_f = 1'b0, mv_r = 1'b0;
  int           mp_f = 0, mp_r = 0;
  logic         m_cf = 1'b0;
  logic [15:0]  m_cnt = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int first_req(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return -1;
  endfunction

  task automatic model_arb(input bit rr, inout logic [N-1:0] g, inout logic [W-1:0] b,
                           inout logic v, inout int ptr);
    int w;
    bit hold;
    if (rst) begin
      g = '0; b = '0; v = 1'b0; ptr = 0;
      return;
    end
    if (re == '0) begin
      g = '0; v = 1'b0;
      return;
    end
    hold = lk && (g != '0) && ((re & g) != '0);
    w = hold ? oh_idx(g) : first_req(re, rr ? ptr : 0);
    if (rr && !hold) ptr = (w + 1) % N;
    g = '0;
    g[w] = 1'b1;
    b = src[w*W +: W];
    v = 1'b1;
  endtask

  // Drive one cycle, push the prediction, then pop and compare after the edge.
  task automatic step(input logic [N-1:0] r_en, input logic l, input logic r, input bit chk_on);
    exp_t e;
    re = r_en; lk = l; rst = r;
    model_arb(1'b0, mg_f, mb_f, mv_f, mp_f);
    model_arb(1'b1, mg_r, mb_r, mv_r, mp_r);
    if (r) begin
      m_cf = 1'b0; m_cnt = '0;
    end else begin
      m_cf = ($countones(r_en) >= 2);
      if (m_cf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    e.g_f = mg_f; e.b_f = mb_f; e.v_f = mv_f;
    e.g_r = mg_r; e.b_r = mb_r; e.v_r = mv_r;
`ifdef BUS_ARB_CONFLICT_CNT_EN
    e.cf = m_cf; e.cnt = m_cnt;
`else
    e.cf = 1'b0; e.cnt = '0;
`endif
    e.chk = chk_on;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk) begin
      check("grant_fix", 32'(gnt_f), 32'(e.g_f));
      check("bus_fix",   32'(bus_f), 32'(e.b_f));
      check("valid_fix", 32'(val_f), 32'(e.v_f));
      check("grant_rr",  32'(gnt_r), 32'(e.g_r));
      check("bus_rr",    32'(bus_r), 32'(e.b_r));
      check("valid_rr",  32'(val_r), 32'(e.v_r));
      check("conflict",  32'(cf_f),  32'(e.cf));
      check("cnt",       32'(cnt_f), 32'(e.cnt));
      check("cnt_rr",    32'(cnt_r), 32'(e.cnt));
    end
  endtask

  task automatic rand_src();
    for (int i = 0; i < N; i++) src[i*W +: W] = W'($urandom);
  endtask

  initial begin
    int seq [4];
    logic [N-1:0] eg;
    logic [N-1:0] rnd;
    logic         exp_cf;
    logic [15:0]  exp_cnt;
    seq = '{0, 3, 12, 0};
    rst = 1'b1; re = '0; lk = 1'b0;
    rand_src();
    @(negedge clk);

    // Reset state
    step('0, 1'b0, 1'b1, 1'b1);
    check("rst_grant", 32'(gnt_f), 32'h0);
    check("rst_valid", 32'(val_f), 32'h0);
    check("rst_bus",   32'(bus_f), 32'h0);

    // Fixed priority with three requesters
    rand_src();
    src[2*W +: W] = 16'h1234;
    step(13'b0000000100110, 1'b0, 1'b0, 1'b1);
    check("fix_p_grant", 32'(gnt_f), 32'h2);
    check("fix_p_bus",   32'(bus_f), 32'(src[1*W +: W]));
`ifdef BUS_ARB_CONFLICT_CNT_EN
    exp_cf = 1'b1; exp_cnt = 16'd1;
`else
    exp_cf = 1'b0; exp_cnt = 16'd0;
`endif
    check("fix_p_conflict", 32'(cf_f),  32'(exp_cf));
    check("fix_p_cnt",      32'(cnt_f), 32'(exp_cnt));

    // Round-robin rotation with wrap
    step('0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      rand_src();
      step(13'h1009, 1'b0, 1'b0, 1'b1);
      eg = '0;
      eg[seq[k]] = 1'b1;
      check("rr_seq", 32'(gnt_r), 32'(eg));
    end

    // Idle hold
    src[5*W +: W] = 16'hBEEF;
    step(13'h0020, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      rand_src();
      step('0, 1'b0, 1'b0, 1'b1);
      check("idle_bus",   32'(bus_f), 32'hBEEF);
      check("idle_valid", 32'(val_f), 32'h0);
      check("idle_grant", 32'(gnt_f), 32'h0);
    end

    // Lock retention and release
    step(13'h0010, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      rand_src();
      step(13'h0011, 1'b1, 1'b0, 1'b1);
      check("lock_fix", 32'(gnt_f), 32'h10);
      check("lock_rr",  32'(gnt_r), 32'h10);
    end
    step(13'h0001, 1'b1, 1'b0, 1'b1);
    check("unlock_fix", 32'(gnt_f), 32'h1);
    check("unlock_rr",  32'(gnt_r), 32'h1);

    // Reset during ownership clears the lock
    step(13'h0010, 1'b1, 1'b0, 1'b1);
    step(13'h0010, 1'b1, 1'b1, 1'b1);
    step(13'h0012, 1'b1, 1'b0, 1'b1);
    check("rst_unlock_fix", 32'(gnt_f), 32'h2);
    check("rst_unlock_rr",  32'(gnt_r), 32'h2);

    // Random traffic
    for (int k = 0; k < 80; k++) begin
      rand_src();
      rnd = N'($urandom) & N'($urandom);
      if ($urandom_range(0, 3) == 0) rnd = '0;
      step(rnd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0), 1'b1);
    end

    // Counter saturation, then reset
    step('0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 65534; k++) step(13'h1006, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(13'h1006, 1'b0, 1'b0, 1'b1);
`ifdef BUS_ARB_CONFLICT_CNT_EN
      exp_cnt = 16'hFFFF;
`else
      exp_cnt = 16'h0;
`endif
      check("sat_cnt", 32'(cnt_f), 32'(exp_cnt));
    end
    step(13'h1006, 1'b0, 1'b1, 1'b1);
    check("sat_rst_cnt",   32'(cnt_f), 32'h0);
    check("sat_rst_cf",    32'(cf_f),  32'h0);
    check("sat_rst_grant", 32'(gnt_r), 32'h0);
    check("sat_rst_bus",   32'(bus_r), 32'h0);
    step(13'h1FFF, 1'b0, 1'b0, 1'b1);
    check("ptr_zero", 32'(gnt_r), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter WIDTH, default 16, bit width of every source and of the bus.
REQ-002 Parameter N_SRC, default 13, number of bus sources; legal range 2..32.
REQ-003 Parameter MODE, default ARB_FIXED, arbitration mode: ARB_FIXED or ARB_RR.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port src_data  input  N_SRC*WIDTH  packed source words; source i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port read_en  input  N_SRC  per-source request to drive the bus.
REQ-008 Port lock  input  1  when high, the current owner keeps the bus while its read_en stays high.
REQ-009 Port bus  output  WIDTH  registered bus value.
REQ-010 Port bus_valid  output  1  high for the cycle after a grant.
REQ-011 Port grant  output  N_SRC  registered one-hot owner of the current bus value; all-zero when idle.
REQ-012 Port conflict  output  1  registered; high if two or more read_en bits were high on the previous edge.
REQ-013 Port conflict_cnt  output  16  saturating count of conflict cycles.

Function
REQ-014 Latency is one cycle: the winner sampled at edge k drives bus, grant and bus_valid from edge k onward.
REQ-015 No read_en high: bus holds its last value, bus_valid <= 0, grant <= 0.
REQ-016 ARB_FIXED: lowest index with read_en high wins; index 0 is the highest priority.
REQ-017 ARB_RR: a pointer ptr (0..N_SRC-1) selects the first requester at index ptr, ptr+1, ..., wrapping from N_SRC-1 to 0.
REQ-018 ARB_RR: after each grant, ptr <= (winner+1) mod N_SRC; ptr is unchanged on idle cycles.
REQ-019 Lock: if lock is high, grant is non-zero, and read_en of the current owner is high, the owner wins regardless of mode or priority; ptr does not advance.
REQ-020 Lock is released when the owner drops read_en, even if lock stays high; normal arbitration applies on that same edge.
REQ-021 Lock high with grant all-zero has no effect.
REQ-022 conflict_cnt increments by 1 on each edge where popcount(read_en) >= 2, and saturates at 0xFFFF.
REQ-023 grant is always zero or one-hot; bus always equals src_data of the granted source as sampled at the grant edge.

Reset
REQ-024 When rst is high at an edge: bus = 0, bus_valid = 0, grant = 0, conflict = 0, conflict_cnt = 0, ptr = 0; this overrides all requests and lock.
REQ-025 Reset asserted mid-ownership releases the lock; the first edge after reset arbitrates from a clean state.

Configuration
REQ-026 Macro BUS_ARB_CONFLICT_CNT_EN defined: conflict and conflict_cnt behave per REQ-012 and REQ-022.
REQ-027 Macro BUS_ARB_CONFLICT_CNT_EN undefined: conflict and conflict_cnt are tied to 0 and no counter logic is built; all other behaviour is unchanged.

Structure
REQ-028 Package bus_arb_pkg holds the mode enum (ARB_FIXED, ARB_RR), the default WIDTH and N_SRC constants, and an index-width function (clog2 of N_SRC).
REQ-029 Sub-module bus_arb_pick is a combinational rotated priority picker: inputs are the request vector and start index; outputs are the one-hot winner and its index.
REQ-030 bus_arbiter holds all state: bus, grant, ptr, lock ownership and the counter.

Verification
REQ-031 Fixed priority: MODE=ARB_FIXED, read_en=0b0000000100110, src2=0x1234 -> next cycle grant=bit1, bus=src1, conflict=1, conflict_cnt=1.
REQ-032 Round-robin: MODE=ARB_RR, read_en bits 0, 3 and 12 held high for 4 cycles -> grant sequence 0, 3, 12, 0; ptr wraps 13 -> 0.
REQ-033 Idle hold: grant src5 with 0xBEEF, then read_en=0 for 3 cycles -> bus=0xBEEF, bus_valid=0, grant=0 throughout.
REQ-034 Lock: src4 owns the bus with lock=1, then src0 requests -> src4 retained for each cycle its read_en stays high; src4 drops read_en -> src0 granted on the next edge.
REQ-035 Saturation and reset: force conflict_cnt to 0xFFFE, apply 3 conflict cycles -> 0xFFFF held; then rst=1 for 1 cycle -> all outputs 0, ptr=0.
REQ-036 Configuration: build without BUS_ARB_CONFLICT_CNT_EN and rerun REQ-031 -> conflict=0 and conflict_cnt=0; grant and bus are identical to REQ-031.
